// File: rtl/uart_host.sv
// rtl/uart_host.sv - 8N1 UART host with RX/TX FIFOs, CTRL/STAT/DATA registers, RTS/CTS and level IRQ
module uart_host #(
  parameter int RXFIFO_DEPTH_BITS = 4,
  parameter int TXFIFO_DEPTH_BITS = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx_pin_i,
  output logic       tx_pin_o,
  output logic       txde_o,
  input  logic       cts_pin_i,
  output logic       rts_pin_o,
  output logic [7:0] reg_d_o,
  input  logic [7:0] reg_d_i,
  input  logic       reg_wr_i,
  input  logic       reg_rd_i,
  input  logic       reg_cs_ctrl_i,
  input  logic       reg_cs_stat_i,
  input  logic       reg_cs_data_i,
  output logic       irq_o
);
  localparam int RB = RXFIFO_DEPTH_BITS;
  localparam int TB = TXFIFO_DEPTH_BITS;
  localparam logic [RB:0] RX_DEPTH   = (RB+1)'(1 << RB);
  localparam logic [RB:0] RX_RTS_LVL = (RB+1)'((1 << RB) - 2);
  localparam logic [TB:0] TX_DEPTH   = (TB+1)'(1 << TB);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
  state_t tx_state, tx_next, rx_state, rx_next;

  logic [5:0]    ctrl;
  logic          rx_ferr, rx_ovf, tx_ovf;
  logic [7:0]    rx_mem [1 << RB];
  logic [7:0]    tx_mem [1 << TB];
  logic [RB-1:0] rx_wp, rx_rp;
  logic [RB:0]   rx_cnt;
  logic [TB-1:0] tx_wp, tx_rp;
  logic [TB:0]   tx_cnt;
  logic          rx_s1, rx_s, rx_prev, cts_s1, cts_s;
  logic [12:0]   tx_div, tx_bcnt, rx_div, rx_bcnt;
  logic [2:0]    tx_bit, rx_bit;
  logic [7:0]    tx_shift, rx_shift;
  logic [7:0]    stat;

  function automatic logic [12:0] baud_div(input logic [2:0] sel);
    case (sel)
      3'd0:    baud_div = 13'd5000;
      3'd1:    baud_div = 13'd2500;
      3'd2:    baud_div = 13'd1250;
      3'd3:    baud_div = 13'd833;
      3'd4:    baud_div = 13'd417;
      3'd5:    baud_div = 13'd208;
      3'd6:    baud_div = 13'd48;
      default: baud_div = 13'd16;
    endcase
  endfunction

  logic wr_ctrl, wr_stat, wr_data, rd_data;
  logic rx_empty, rx_full, tx_empty, tx_full, tx_idle;
  logic tx_push, tx_start, rx_pop, rx_push, rx_stop_evt;
  logic tx_tick, rx_tick, rx_half, rx_fall;

  assign wr_ctrl  = reg_wr_i & reg_cs_ctrl_i;
  assign wr_stat  = reg_wr_i & reg_cs_stat_i;
  assign wr_data  = reg_wr_i & reg_cs_data_i;
  assign rd_data  = reg_rd_i & reg_cs_data_i;
  assign rx_empty = (rx_cnt == '0);
  assign rx_full  = (rx_cnt == RX_DEPTH);
  assign tx_empty = (tx_cnt == '0);
  assign tx_full  = (tx_cnt == TX_DEPTH);
  assign tx_idle  = tx_empty & (tx_state == S_IDLE);

  assign tx_push     = wr_data & ~tx_full;
  assign rx_pop      = rd_data & ~rx_empty;
  // CTS is only consulted here, so a frame in flight always completes
  assign tx_start    = (tx_state == S_IDLE) & ~tx_empty & ~(ctrl[3] & cts_s);
  assign tx_tick     = (tx_bcnt == tx_div - 13'd1);
  assign rx_tick     = (rx_bcnt == rx_div - 13'd1);
  assign rx_half     = (rx_bcnt == (rx_div >> 1) - 13'd1);
  assign rx_fall     = rx_prev & ~rx_s;
  assign rx_stop_evt = (rx_state == S_STOP) & rx_tick;
  assign rx_push     = rx_stop_evt & rx_s & ~rx_full;

  assign stat      = {rx_empty, rx_full, rx_ferr, rx_ovf, tx_full, tx_empty, tx_ovf, tx_idle};
  assign rts_pin_o = ctrl[3] & (rx_cnt >= RX_RTS_LVL);

  always_comb begin
    reg_d_o = 8'h00;
    if (reg_cs_data_i)      reg_d_o = rx_empty ? 8'h00 : rx_mem[rx_rp];
    else if (reg_cs_stat_i) reg_d_o = stat;
    else if (reg_cs_ctrl_i) reg_d_o = {2'b00, ctrl};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_state <= S_IDLE;
      rx_state <= S_IDLE;
    end else begin
      tx_state <= tx_next;
      rx_state <= rx_next;
    end
  end

  always_comb begin
    tx_next  = tx_state;
    tx_pin_o = 1'b1;
    txde_o   = 1'b0;
    case (tx_state)
      S_IDLE:  if (tx_start) tx_next = S_START;
      S_START: begin
        tx_pin_o = 1'b0;
        txde_o   = 1'b1;
        if (tx_tick) tx_next = S_DATA;
      end
      S_DATA: begin
        tx_pin_o = tx_shift[0];
        txde_o   = 1'b1;
        if (tx_tick && tx_bit == 3'd7) tx_next = S_STOP;
      end
      S_STOP: begin
        txde_o = 1'b1;
        if (tx_tick) tx_next = S_IDLE;
      end
      default: tx_next = S_IDLE;
    endcase
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      S_IDLE:  if (rx_fall) rx_next = S_START;
      S_START: if (rx_half) rx_next = rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = S_STOP;
      S_STOP:  if (rx_tick) rx_next = S_IDLE;
      default: rx_next = S_IDLE;
    endcase
  end

  // FIFO storage carries no reset; occupancy counters alone define validity
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= reg_d_i;
    if (rx_push) rx_mem[rx_wp] <= rx_shift;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ctrl     <= 6'h04;
      rx_ferr  <= 1'b0;
      rx_ovf   <= 1'b0;
      tx_ovf   <= 1'b0;
      rx_wp    <= '0;
      rx_rp    <= '0;
      rx_cnt   <= '0;
      tx_wp    <= '0;
      tx_rp    <= '0;
      tx_cnt   <= '0;
      rx_s1    <= 1'b1;
      rx_s     <= 1'b1;
      rx_prev  <= 1'b1;
      cts_s1   <= 1'b1;
      cts_s    <= 1'b1;
      tx_div   <= '0;
      tx_bcnt  <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      rx_div   <= '0;
      rx_bcnt  <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      irq_o    <= 1'b0;
    end else begin
      rx_s1   <= rx_pin_i;
      rx_s    <= rx_s1;
      rx_prev <= rx_s;
      cts_s1  <= cts_pin_i;
      cts_s   <= cts_s1;
      irq_o   <= (ctrl[4] & ~rx_empty) | (ctrl[5] & tx_empty);

      if (wr_ctrl) ctrl <= reg_d_i[5:0];
      if (wr_stat && reg_d_i[5]) rx_ferr <= 1'b0;
      if (wr_stat && reg_d_i[4]) rx_ovf  <= 1'b0;
      if (wr_stat && reg_d_i[1]) tx_ovf  <= 1'b0;
      if (wr_data && tx_full) tx_ovf <= 1'b1;
      if (rx_stop_evt && !rx_s) rx_ferr <= 1'b1;
      if (rx_stop_evt && rx_s && rx_full) rx_ovf <= 1'b1;

      if (tx_push)  tx_wp <= tx_wp + TB'(1);
      if (tx_start) tx_rp <= tx_rp + TB'(1);
      case ({tx_push, tx_start})
        2'b10:   tx_cnt <= tx_cnt + (TB+1)'(1);
        2'b01:   tx_cnt <= tx_cnt - (TB+1)'(1);
        default: ;
      endcase
      if (rx_push) rx_wp <= rx_wp + RB'(1);
      if (rx_pop)  rx_rp <= rx_rp + RB'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + (RB+1)'(1);
        2'b01:   rx_cnt <= rx_cnt - (RB+1)'(1);
        default: ;
      endcase

      // Divisors are latched at frame start so baud changes never split a frame
      if (tx_start) begin
        tx_shift <= tx_mem[tx_rp];
        tx_div   <= baud_div(ctrl[2:0]);
        tx_bcnt  <= '0;
        tx_bit   <= '0;
      end else if (tx_state != S_IDLE) begin
        tx_bcnt <= tx_tick ? 13'd0 : tx_bcnt + 13'd1;
        if (tx_state == S_DATA && tx_tick) begin
          tx_shift <= tx_shift >> 1;
          tx_bit   <= tx_bit + 3'd1;
        end
      end

      case (rx_state)
        S_IDLE: begin
          rx_bcnt <= '0;
          rx_bit  <= '0;
          if (rx_fall) rx_div <= baud_div(ctrl[2:0]);
        end
        S_START: rx_bcnt <= rx_half ? 13'd0 : rx_bcnt + 13'd1;
        default: begin
          rx_bcnt <= rx_tick ? 13'd0 : rx_bcnt + 13'd1;
          if (rx_state == S_DATA && rx_tick) begin
            rx_shift <= {rx_s, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_host.sv
// tb/tb_uart_host.sv - scoreboard bench for uart_host: loopback, FIFO limits, framing, IRQ, reset
module tb_uart_host;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       rx_pin, tx_pin, txde, cts = 1'b0, rts, irq;
  logic [7:0] reg_d_o, reg_d = 8'h00;
  logic       reg_wr = 1'b0, reg_rd = 1'b0;
  logic       cs_ctrl = 1'b0, cs_stat = 1'b0, cs_data = 1'b0;
  logic       loop_en = 1'b0, rx_drive = 1'b1;
  logic       chk_en = 1'b0, poll_ok = 1'b0;
  logic [7:0] pat [17];

  typedef struct {
    string      name;
    int         kind;
    logic [7:0] exp;
  } item_t;
  item_t sb[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  assign rx_pin = loop_en ? tx_pin : rx_drive;

  uart_host dut (
    .clk(clk), .resetn(resetn), .rx_pin_i(rx_pin), .tx_pin_o(tx_pin), .txde_o(txde),
    .cts_pin_i(cts), .rts_pin_o(rts), .reg_d_o(reg_d_o), .reg_d_i(reg_d),
    .reg_wr_i(reg_wr), .reg_rd_i(reg_rd), .reg_cs_ctrl_i(cs_ctrl),
    .reg_cs_stat_i(cs_stat), .reg_cs_data_i(cs_data), .irq_o(irq)
  );

  // kind: 0 reg_d_o, 1 tx_pin, 2 txde, 3 rts, 4 irq, 5 poll completed in budget
  always @(negedge clk) begin
    item_t it;
    logic [7:0] act;
    if (chk_en) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow: check strobe with no expected value");
      end else begin
        it = sb.pop_front();
        case (it.kind)
          0:       act = reg_d_o;
          1:       act = {7'b0, tx_pin};
          2:       act = {7'b0, txde};
          3:       act = {7'b0, rts};
          4:       act = {7'b0, irq};
          default: act = {7'b0, poll_ok};
        endcase
        if (act !== it.exp) begin
          errors++;
          $display("FAIL %s: got 0x%02h expected 0x%02h", it.name, act, it.exp);
        end
      end
    end
  end

  task automatic set_cs(input int sel);
    cs_ctrl = (sel == 0);
    cs_stat = (sel == 1);
    cs_data = (sel == 2);
  endtask

  task automatic reg_write(input int sel, input logic [7:0] d);
    @(posedge clk); #1;
    set_cs(sel); reg_wr = 1'b1; reg_d = d;
    @(posedge clk); #1;
    set_cs(-1); reg_wr = 1'b0;
  endtask

  task automatic chk_reg(input int sel, input logic rd, input logic [7:0] exp, input string name);
    sb.push_back('{name, 0, exp});
    @(posedge clk); #1;
    set_cs(sel); reg_rd = rd; chk_en = 1'b1;
    @(posedge clk); #1;
    set_cs(-1); reg_rd = 1'b0; chk_en = 1'b0;
  endtask

  task automatic chk_pin(input int kind, input logic v, input string name);
    sb.push_back('{name, kind, {7'b0, v}});
    @(posedge clk); #1 chk_en = 1'b1;
    @(posedge clk); #1 chk_en = 1'b0;
  endtask

  task automatic poll_stat(input int b, input logic v, input int max, input string name);
    logic ok = 1'b0;
    for (int n = 0; n < max && !ok; n++) begin
      @(posedge clk); #1 cs_stat = 1'b1;
      @(negedge clk);
      if (reg_d_o[b] === v) ok = 1'b1;
    end
    @(posedge clk); #1 cs_stat = 1'b0;
    poll_ok = ok;
    chk_pin(5, 1'b1, name);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int div);
    rx_drive = 1'b0;
    repeat (div) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drive = b[i];
      repeat (div) @(posedge clk);
    end
    rx_drive = stop;
    repeat (div) @(posedge clk);
    rx_drive = 1'b1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 17; i++) pat[i] = 8'((i * 37 + 5) & 8'hFF);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    chk_reg(1, 1'b0, 8'h85, "reset_stat");
    chk_reg(0, 1'b0, 8'h04, "reset_ctrl");
    chk_reg(2, 1'b1, 8'h00, "empty_data_read");
    chk_pin(1, 1'b1, "reset_tx_pin");
    chk_pin(2, 1'b0, "reset_txde");
    chk_pin(3, 1'b0, "reset_rts");
    chk_pin(4, 1'b0, "reset_irq");

    @(posedge clk); #1 reg_wr = 1'b1; reg_d = 8'hFF;
    repeat (5) @(posedge clk);
    #1 reg_wr = 1'b0;
    chk_reg(1, 1'b0, 8'h85, "wr_without_cs");

    loop_en = 1'b1;
    reg_write(2, 8'hA5);
    reg_write(2, 8'h5A);
    poll_stat(2, 1'b1, 20000, "lb_tx_empty");
    poll_stat(7, 1'b0, 20000, "lb_rx_nonempty");
    @(posedge clk); #1 cs_stat = 1'b1; reg_rd = 1'b1;
    repeat (5) @(posedge clk);
    #1 cs_stat = 1'b0; reg_rd = 1'b0;
    chk_reg(2, 1'b1, 8'hA5, "lb_byte0");
    poll_stat(0, 1'b1, 20000, "lb_tx_idle");
    poll_stat(7, 1'b0, 2000, "lb_rx_byte1");
    chk_reg(2, 1'b1, 8'h5A, "lb_byte1");
    chk_reg(1, 1'b0, 8'h85, "lb_stat_end");

    cts = 1'b1;
    reg_write(0, 8'h0F);
    for (int i = 0; i < 17; i++) reg_write(2, pat[i]);
    chk_reg(1, 1'b0, 8'h8A, "tx_full_ovf");
    reg_write(1, 8'h02);
    chk_reg(1, 1'b0, 8'h88, "tx_ovf_clear");
    cts = 1'b0;
    poll_stat(3, 1'b0, 200, "tx_drain_start");
    reg_write(2, pat[16]);
    poll_stat(0, 1'b1, 10000, "lb17_tx_idle");
    chk_pin(3, 1'b1, "rts_high_full");
    chk_reg(1, 1'b0, 8'h55, "rx_full_ovf");
    for (int i = 0; i < 16; i++) chk_reg(2, 1'b1, pat[i], $sformatf("lb17_byte%0d", i));
    chk_reg(1, 1'b0, 8'h95, "rx_drained");
    chk_pin(3, 1'b0, "rts_low_empty");

    loop_en = 1'b0;
    reg_write(1, 8'h32);
    reg_write(0, 8'h14);
    send_frame(8'h81, 1'b0, 417);
    repeat (20) @(posedge clk);
    chk_reg(1, 1'b0, 8'hA5, "framing_err");
    reg_write(1, 8'h20);
    chk_reg(1, 1'b0, 8'h85, "framing_clear");
    rx_drive = 1'b0;
    repeat (3) @(posedge clk);
    rx_drive = 1'b1;
    repeat (600) @(posedge clk);
    chk_reg(1, 1'b0, 8'h85, "glitch_ignored");
    chk_pin(4, 1'b0, "irq_idle");
    send_frame(8'h3C, 1'b1, 417);
    repeat (20) @(posedge clk);
    chk_pin(4, 1'b1, "irq_rx_set");
    chk_reg(2, 1'b1, 8'h3C, "rx_byte");
    chk_pin(4, 1'b0, "irq_after_pop");

    reg_write(2, 8'h00);
    repeat (1000) @(posedge clk);
    chk_pin(1, 1'b0, "tx_mid_frame");
    chk_pin(2, 1'b1, "txde_mid_frame");
    @(posedge clk); #1 resetn = 1'b0;
    chk_pin(1, 1'b1, "reset_abort_tx");
    chk_pin(2, 1'b0, "reset_abort_txde");
    chk_reg(1, 1'b0, 8'h85, "reset_abort_stat");
    chk_reg(0, 1'b0, 8'h04, "reset_abort_ctrl");
    @(posedge clk); #1 resetn = 1'b1;
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_host.md
Name: uart_host

Overview:
- Memory-mapped 8N1 UART host controller with RX and TX FIFOs, a CPU register interface (CTRL, STAT, DATA), optional RTS/CTS hardware flow control, a drive-enable output for RS-485 transceivers, and a level interrupt.
- Sits between the FPGA UART pins and the NORA bus register decoder.
- Runs from the 48 MHz system clock.

Parameters:
- RXFIFO_DEPTH_BITS, 4: log2 of RX FIFO depth (4 gives 16 entries).
- TXFIFO_DEPTH_BITS, 4: log2 of TX FIFO depth (4 gives 16 entries).

Ports:
- clk  in  1  system clock, 48 MHz.
- resetn  in  1  asynchronous active-low reset.
- rx_pin_i  in  1  UART RX pin, asynchronous, idle high.
- tx_pin_o  out  1  UART TX pin, idle high.
- txde_o  out  1  TX drive enable, active high.
- cts_pin_i  in  1  clear-to-send, active low.
- rts_pin_o  out  1  request-to-send, active low.
- reg_d_o  out  8  read data of the selected register.
- reg_d_i  in  8  write data.
- reg_wr_i  in  1  write strobe.
- reg_rd_i  in  1  read strobe.
- reg_cs_ctrl_i  in  1  select CTRL register.
- reg_cs_stat_i  in  1  select STAT register.
- reg_cs_data_i  in  1  select DATA register (FIFOs).
- irq_o  out  1  interrupt, active high, level.

Behaviour:
- Reset values: all state cleared, FIFOs empty, CTRL=0x04; tx_pin_o=1, txde_o=0, rts_pin_o=0, irq_o=0.
- Register access:
  - A write occurs on a rising edge where reg_wr_i and a chip-select are both 1.
  - A read side effect occurs on a rising edge where reg_rd_i and reg_cs_data_i are both 1.
  - A strobe held high while its chip-select is low does nothing. Each edge with strobe and select high is one access.
- reg_d_o is combinational:
  - cs_data: RX FIFO head (show-ahead). Returns 0x00 when empty.
  - cs_stat: STAT.
  - cs_ctrl: CTRL.
  - none selected: 0x00.
  - The value is valid in the same cycle the select is asserted. The pop occurs at the end of that cycle.
- DATA write pushes reg_d_i into the TX FIFO. A write when the FIFO is full is dropped and sets tx_ovf.
- DATA read pops the RX FIFO. A pop when empty is ignored.
- CTRL layout (read/write):
  - [2:0] baud select, at 48 MHz, as baud/divisor: 0=9600/5000, 1=19200/2500, 2=38400/1250, 3=57600/833, 4=115200/417, 5=230400/208, 6=1M/48, 7=3M/16.
  - [3] hardware flow-control enable.
  - [4] RX IRQ enable.
  - [5] TX IRQ enable.
  - [7:6] read 0.
- STAT layout:
  - [7] RX FIFO empty.
  - [6] RX FIFO full.
  - [5] RX framing error, sticky.
  - [4] RX overflow, sticky.
  - [3] TX FIFO full.
  - [2] TX FIFO empty.
  - [1] tx_ovf, sticky.
  - [0] TX idle: FIFO empty and shifter idle.
  - Reading STAT has no side effects. Writing STAT with 1 in bit 5, 4 or 1 clears that sticky bit.
- Simultaneous push and pop on the same FIFO in one cycle are both honoured. Occupancy is unchanged and pointers wrap modulo the depth.
- TX path:
  - When idle and the FIFO is non-empty (and, if flow control is enabled, cts_pin_i=0), the transmitter pops a byte.
  - Frame: start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts one divisor count.
  - txde_o=1 from the start bit through the end of the stop bit, else 0.
  - CTS is checked only between frames.
- RX path:
  - rx_pin_i passes through a 2-FF synchronizer.
  - A falling edge starts reception. The start bit is re-sampled at half a bit; if it reads 1, the event is a glitch and RX returns to idle.
  - Data bits are sampled at bit centres, followed by the stop bit.
  - Stop=1: push the byte. If the RX FIFO is full, drop the byte and set RX overflow.
  - Stop=0: discard the byte and set framing error.
  - RX FSM states: IDLE, START, DATA, STOP. TX FSM states: IDLE, START, DATA, STOP.
- Flow control:
  - Enabled: rts_pin_o=1 when the RX FIFO holds at least depth-2 entries, else 0.
  - Disabled: rts_pin_o=0 and CTS is ignored.
- irq_o = (CTRL[4] & !rx_empty) | (CTRL[5] & tx_empty), registered.
- Baud change takes effect at the next frame start.
- Reset mid-frame aborts the frame immediately: TX line goes high, FIFOs clear.

Test Plan:
- Loopback, default CTRL: write 0xA5 then 0x5A to DATA with single-cycle cs. Poll STAT[2] until set, poll STAT[7] until clear. DATA read returns 0xA5, then 0x5A.
- Hold reg_wr_i=1 with cs_data low for several cycles -> TX FIFO stays empty, STAT[2]=1. Hold reg_rd_i=1 polling STAT -> RX FIFO not popped.
- Write 17 bytes with TX blocked (flow control on, CTS=1) -> STAT[3]=1 and STAT[1]=1. Write STAT=0x02 -> STAT[1]=0.
- Loopback 17 bytes without reading -> STAT[6]=1, STAT[4]=1, and the first 16 bytes are read back in order.
- Drive the RX pin with stop bit 0 -> STAT[5]=1 and the RX FIFO stays empty. CTRL=0x14 with one received byte -> irq_o=1 until popped.
- Assert resetn=0 mid-frame -> tx_pin_o=1, txde_o=0, STAT=0x85 next cycle.
